button_conditioner: RTL
=======================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive clk edges an input must differ from its debounced level before the level flips (minimum 2).
REQ-002 Parameter REPEAT_DELAY, default 64, clk cycles from the first inc pulse to the first auto-repeat pulse (minimum 2).
REQ-003 Parameter REPEAT_RATE, default 32, clk cycles between subsequent auto-repeat pulses (minimum 2).
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 btn_start  input  1  raw, asynchronous, bouncing start pushbutton (1 = pressed).
REQ-007 btn_stop  input  1  raw, asynchronous, bouncing stop pushbutton.
REQ-008 btn_inc  input  1  raw, asynchronous, bouncing increment pushbutton.
REQ-009 start  output  1  one-cycle pulse per debounced start press; feeds the stopwatch control FSM.
REQ-010 stop  output  1  one-cycle pulse per debounced stop press.
REQ-011 inc  output  1  one-cycle pulse per debounced inc press, plus auto-repeat pulses while inc is held.
REQ-012 btn_lvl  output  3  debounced levels {inc, stop, start} (bit 0 = start).

Function
REQ-013 Each raw input SHALL pass through its own 2-flop synchronizer (s1, s2) before any other logic.
REQ-014 Each channel SHALL keep a debounce counter sized for DEBOUNCE_CYCLES; the counter clears on any edge where s2 equals the debounced level.
REQ-015 The counter SHALL increment on each edge where s2 differs from the debounced level; on the DEBOUNCE_CYCLES-th consecutive differing edge, the debounced level takes s2 and the counter clears.
REQ-016 Latency: a raw change held stable that is first sampled by s1 at edge k SHALL flip btn_lvl at edge k+1+DEBOUNCE_CYCLES.
REQ-017 A bounce or glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave btn_lvl unchanged and emit no pulse.
REQ-018 The start, stop and inc outputs SHALL be registered; each is asserted high for exactly the one cycle following the edge at which its debounced level goes 0->1.
REQ-019 Debounced 1->0 transitions SHALL never generate a pulse.
REQ-020 If start and stop debounced levels both rise at the same edge, stop SHALL pulse and start SHALL be suppressed for that press.
REQ-021 The inc channel SHALL run an auto-repeat FSM with states IDLE, HOLD and REPEAT, and a repeat counter.
REQ-022 IDLE->HOLD on debounced inc rise, with a pulse per REQ-018 and the repeat counter cleared.
REQ-023 HOLD: count cycles; on the REPEAT_DELAY-th cycle after the initial pulse, emit an inc pulse, clear the counter and go to REPEAT.
REQ-024 REPEAT: emit an inc pulse every REPEAT_RATE cycles.
REQ-025 Any state ->IDLE at the edge where debounced inc falls; no pulse is emitted at that edge and the counter clears.
REQ-026 The inc output SHALL never be high on two consecutive cycles.

Reset
REQ-027 With rst high at an edge: s1, s2 and the debounced levels SHALL go to 1, so btn_lvl=3'b111.
REQ-028 With rst high at an edge: all counters SHALL go to 0, the FSM to IDLE, and start=stop=inc=0.
REQ-029 Consequence of REQ-027: a button held through reset release SHALL produce no pulse until it is released (debounced low) and pressed again.
REQ-030 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no pulse emitted at or after the reset edge.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3)
REQ-031 Reset with all buttons released -> btn_lvl=111, then 000 at 5 edges after the first post-reset edge; no pulses.
REQ-032 btn_start rises cleanly and is held -> btn_lvl[0] rises at edge k+5; start high for exactly one cycle after that edge; stop=inc=0 throughout.
REQ-033 btn_stop bounces 1,0,1,0 on alternate cycles, then holds 1 -> no pulse during the bounce; exactly one stop pulse, 5 edges after the last bounce is sampled.
REQ-034 btn_start and btn_stop pressed in the same cycle -> one stop pulse; zero start pulses.
REQ-035 btn_inc held for 30 cycles after debounce -> pulses at offsets 0, 8, 11, 14, ..., 29 relative to the first pulse; after release, debounced inc falls and no further pulses occur.
REQ-036 btn_inc held across reset release -> no inc pulse; after release and a re-press, exactly one pulse.

Source files
------------

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - three-button synchronizer, debouncer, press-pulse and inc auto-repeat
// Levels reset high so a button held through reset never looks like a fresh press.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_inc,
  output logic       start,
  output logic       stop,
  output logic       inc,
  output logic [2:0] btn_lvl
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} repState_t;

  logic [2:0]    rawIn;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    level;
  logic [2:0]    settle;
  logic [2:0]    rise;
  logic [2:0]    fall;
  logic [DW-1:0] debCnt [3];

  repState_t     state;
  repState_t     nextState;
  logic [RW-1:0] repCnt;
  logic [RW-1:0] nextRepCnt;
  logic          incNext;

  assign rawIn   = {btn_inc, btn_stop, btn_start};
  assign btn_lvl = level;

  // settle marks the edge on which a channel's debounced level takes s2
  always_comb begin
    settle = '0;
    for (int i = 0; i < 3; i++) begin
      settle[i] = (sync2[i] != level[i]) && (debCnt[i] == DEB_LAST);
    end
    rise = settle & sync2;
    fall = settle & ~sync2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      level <= '1;
      for (int i = 0; i < 3; i++) begin
        debCnt[i] <= '0;
      end
    end else begin
      sync1 <= rawIn;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          debCnt[i] <= '0;
        end else if (settle[i]) begin
          level[i]  <= sync2[i];
          debCnt[i] <= '0;
        end else begin
          debCnt[i] <= debCnt[i] + DW'(1);
        end
      end
    end
  end

  // A simultaneous start+stop press resolves to stop
  always_ff @(posedge clk) begin
    if (rst) begin
      start <= 1'b0;
      stop  <= 1'b0;
    end else begin
      start <= rise[0] & ~rise[1];
      stop  <= rise[1];
    end
  end

  always_comb begin
    nextState  = state;
    nextRepCnt = repCnt;
    incNext    = 1'b0;
    if (fall[2]) begin
      nextState  = IDLE;
      nextRepCnt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise[2]) begin
            nextState  = HOLD;
            nextRepCnt = '0;
            incNext    = 1'b1;
          end
        end
        HOLD: begin
          if (repCnt == DELAY_LAST) begin
            nextState  = REPEAT;
            nextRepCnt = '0;
            incNext    = 1'b1;
          end else begin
            nextRepCnt = repCnt + RW'(1);
          end
        end
        REPEAT: begin
          if (repCnt == RATE_LAST) begin
            nextRepCnt = '0;
            incNext    = 1'b1;
          end else begin
            nextRepCnt = repCnt + RW'(1);
          end
        end
        default: begin
          nextState  = IDLE;
          nextRepCnt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      repCnt <= '0;
      inc    <= 1'b0;
    end else begin
      state  <= nextState;
      repCnt <= nextRepCnt;
      inc    <= incNext;
    end
  end

endmodule
